// File: rtl/param_alu_mux.sv
// Three-state ALU/mux. It captures the operands on start, computes during EXEC,
// and registers Y and the flags together with a one-cycle valid pulse on entry to DONE.
module param_alu_mux #(
  parameter int WIDTH  = 8,
  parameter int ACC_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       Sel,
  input  logic             acc_mode,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] Y,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_sel;
  logic             r_acc;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;
  logic             r_valid;

  logic [WIDTH-1:0] w_opa;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_y;
  logic             w_carry;
  logic             w_ovf;

  // Y does not change between capture and the EXEC->DONE edge,
  // so the live Y register is the same value as Y at capture time.
  assign w_opa  = ((ACC_EN != 0) && r_acc) ? r_y : r_a;
  assign w_sum  = {1'b0, w_opa} + {1'b0, r_b};
  assign w_diff = {1'b0, w_opa} - {1'b0, r_b};

  always_comb begin
    w_y     = w_opa;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (r_sel)
      2'b00: w_y = w_opa;
      2'b01: w_y = r_b;
      2'b10: begin
        w_y     = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (w_opa[WIDTH-1] == r_b[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != w_opa[WIDTH-1]);
      end
      default: begin
        w_y     = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (w_opa[WIDTH-1] != r_b[WIDTH-1]) &&
                  (w_diff[WIDTH-1] != w_opa[WIDTH-1]);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_acc   <= 1'b0;
      r_y     <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_sel   <= Sel;
            r_acc   <= acc_mode;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_y     <= w_y;
          r_carry <= w_carry;
          r_ovf   <= w_ovf;
          r_zero  <= (w_y == '0);
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == S_EXEC) || (r_state == S_DONE);
  assign valid    = r_valid;
  assign Y        = r_y;
  assign carry    = r_carry;
  assign overflow = r_ovf;
  assign zero     = r_zero;

endmodule

// File: tb/tb_param_alu_mux.sv
// Directed-vector bench for param_alu_mux (WIDTH=8, ACC_EN=1).
module tb_param_alu_mux;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [1:0] Sel;
  logic       acc_mode;
  logic       busy;
  logic       valid;
  logic [7:0] Y;
  logic       carry;
  logic       overflow;
  logic       zero;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  param_alu_mux #(.WIDTH(8), .ACC_EN(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .Sel      (Sel),
    .acc_mode (acc_mode),
    .busy     (busy),
    .valid    (valid),
    .Y        (Y),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge, with the DUT in IDLE.
  // Inputs are scrambled right after the start edge to prove they were captured.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] sel, input logic acc,
                       input logic [7:0] ey, input logic ec, input logic ev, input logic ez);
    A = a; B = b; Sel = sel; acc_mode = acc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = ~b; Sel = ~sel; acc_mode = ~acc;
    chk({tag, ".exec_busy"}, busy, 1);
    chk({tag, ".exec_valid"}, valid, 0);
    @(posedge clk); #1;
    chk({tag, ".done_busy"}, busy, 1);
    chk({tag, ".done_valid"}, valid, 1);
    chk({tag, ".Y"}, Y, ey);
    chk({tag, ".carry"}, carry, ec);
    chk({tag, ".ovf"}, overflow, ev);
    chk({tag, ".zero"}, zero, ez);
    @(posedge clk); #1;
    chk({tag, ".idle_busy"}, busy, 0);
    chk({tag, ".idle_valid"}, valid, 0);
    chk({tag, ".Y_hold"}, Y, ey);
  endtask

  initial begin
    int unsigned vcount;
    reset = 1'b1; start = 1'b0; A = '0; B = '0; Sel = '0; acc_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.Y", Y, 8'h00);
    chk("rst.valid", valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.carry", carry, 0);
    chk("rst.ovf", overflow, 0);
    chk("rst.zero", zero, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op("add_1_2",   8'h01, 8'h02, 2'b10, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    do_op("add_ff_1",  8'hFF, 8'h01, 2'b10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    do_op("add_7f_1",  8'h7F, 8'h01, 2'b10, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    do_op("sub_1_2",   8'h01, 8'h02, 2'b11, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    do_op("sub_80_1",  8'h80, 8'h01, 2'b11, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    do_op("pass_a",    8'h5A, 8'hC3, 2'b00, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);
    do_op("pass_b",    8'h5A, 8'hC3, 2'b01, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);

    do_op("acc_seed",  8'h01, 8'h02, 2'b10, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    do_op("acc_add1",  8'hAA, 8'h05, 2'b10, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    do_op("acc_add2",  8'hAA, 8'h05, 2'b10, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0);
    do_op("acc_sub",   8'hAA, 8'h0E, 2'b11, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    do_op("acc_passb", 8'hAA, 8'h00, 2'b01, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

    // Second start held through the EXEC cycle must not launch another operation.
    A = 8'h10; B = 8'h20; Sel = 2'b10; acc_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    A = 8'h01; B = 8'h01;
    vcount = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 0) start = 1'b0;
      if (valid) vcount++;
    end
    chk("dbl_start.pulses", vcount, 1);
    chk("dbl_start.Y", Y, 8'h30);
    chk("dbl_start.busy", busy, 0);

    // Reset during EXEC aborts the operation.
    A = 8'h11; B = 8'h22; Sel = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort.busy_exec", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.Y", Y, 8'h00);
    chk("abort.valid", valid, 0);
    chk("abort.carry", carry, 0);
    vcount = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (valid) vcount++;
    end
    chk("abort.pulses", vcount, 0);

    // Start coincident with reset is dropped.
    A = 8'h04; B = 8'h04; Sel = 2'b10; reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("rst_start.busy", busy, 0);
    @(posedge clk); #1;
    chk("rst_start.busy2", busy, 0);
    chk("rst_start.Y", Y, 8'h00);

    do_op("post_rst",  8'h40, 8'h40, 2'b10, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_alu_mux.md
PARAM_ALU_MUX -- requirements
Module: param_alu_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (minimum 2).
REQ-002 The block SHALL have parameter ACC_EN, default 1; when set to 1, accumulate mode is available, and when set to 0, acc_mode is ignored.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-007 The block SHALL have port A, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port B, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port Sel, input, 2 bits: operation select (00 pass A, 01 pass B, 10 A+B, 11 A-B).
REQ-010 The block SHALL have port acc_mode, input, 1 bit: when high, the current Y register replaces A as the first operand.
REQ-011 The block SHALL have port busy, output, 1 bit: high in the EXEC and DONE states.
REQ-012 The block SHALL have port valid, output, 1 bit: a one-cycle pulse marking new Y and flags.
REQ-013 The block SHALL have port Y, output, WIDTH bits: registered result, held between operations.
REQ-014 The block SHALL have port carry, output, 1 bit: carry-out for add, borrow for subtract, 0 for pass operations.
REQ-015 The block SHALL have port overflow, output, 1 bit: two's-complement signed overflow for add and subtract, 0 for pass operations.
REQ-016 The block SHALL have port zero, output, 1 bit: high when the newly registered Y equals 0.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC and DONE; transitions SHALL be IDLE->EXEC on start=1, EXEC->DONE unconditionally, and DONE->IDLE unconditionally.
REQ-018 At the edge where start=1 in IDLE, the block SHALL capture A, B, Sel and acc_mode into internal registers; input changes after that edge SHALL NOT affect the operation.
REQ-019 While in EXEC, start SHALL be ignored; while in DONE, start SHALL also be ignored, and no queuing is performed.
REQ-020 At the EXEC->DONE edge, the block SHALL update Y, carry, overflow and zero, and SHALL set valid=1.
REQ-021 valid SHALL be high for exactly the DONE cycle, so latency is 2 edges from the start edge to valid high, and the next start is accepted 3 edges after the previous one.
REQ-022 The first operand (opA) SHALL be the captured Y if acc_mode=1 and ACC_EN=1, and the captured A otherwise.
REQ-023 For Sel=10, Y SHALL be (opA+B) mod 2^WIDTH and carry SHALL be bit WIDTH of the (WIDTH+1)-bit sum.
REQ-024 For Sel=11, Y SHALL be (opA-B) mod 2^WIDTH and carry SHALL be 1 if and only if opA<B (unsigned).
REQ-025 For add, overflow SHALL be 1 if and only if opA and B have equal sign bits and Y's sign differs; for subtract, if and only if the signs of opA and B differ and Y's sign differs from opA's.
REQ-026 For Sel=00 or Sel=01, Y SHALL equal opA or B respectively, with carry=0 and overflow=0.
REQ-027 Y and all flags SHALL hold their values outside the EXEC->DONE edge.
REQ-028 Operand wrap-around SHALL be silent: no saturation, with flags being the only indication.

Reset
REQ-029 When reset=1 at a rising edge, the state SHALL go to IDLE and Y, carry, overflow, zero, valid, busy and the internal capture registers SHALL all be cleared to 0.
REQ-030 Reset SHALL take priority over start and over any in-flight operation; an operation aborted in EXEC or DONE SHALL produce no further valid pulse.
REQ-031 A start asserted in the same cycle as reset SHALL be ignored.

Verification (WIDTH=8, ACC_EN=1)
REQ-032 The bench SHALL check: reset held 2 cycles -> Y=0x00, valid=0, busy=0, carry=overflow=zero=0.
REQ-033 The bench SHALL check: A=0x01, B=0x02, Sel=10, start pulse -> busy=1 for 2 cycles, valid=1 in the 2nd cycle after the start edge, Y=0x03, carry=0, zero=0, overflow=0.
REQ-034 The bench SHALL check: A=0xFF, B=0x01, Sel=10 -> Y=0x00, carry=1, zero=1, overflow=0; then A=0x7F, B=0x01, Sel=10 -> Y=0x80, overflow=1, carry=0.
REQ-035 The bench SHALL check: A=0x01, B=0x02, Sel=11 -> Y=0xFF, carry=1, overflow=0; then A=0x80, B=0x01, Sel=11 -> Y=0x7F, overflow=1, carry=0.
REQ-036 The bench SHALL check: after Y=0x03, acc_mode=1, Sel=10, B=0x05 -> Y=0x08; repeat -> Y=0x0D; then Sel=01, B=0x00 -> Y=0x00, zero=1.
REQ-037 The bench SHALL check: a second start pulsed during EXEC -> ignored (one valid pulse only); and reset asserted during EXEC -> next cycle IDLE, Y=0x00, no valid pulse.
